// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core load/store (port 0) vs DMA/debug (port 1).
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority with a MAX_BURST starvation bound; otherwise round-robin.
module dmem_arbiter #(
  parameter int MAX_BURST  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [1:0]            size0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  err0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [1:0]            size1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err1,
  output logic                  mem_we,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic                  last_winner_q, last_winner_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                  pick0, win0, win1, misaligned, sel_we;
  logic [1:0]            sel_size;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // pick0 decides contention only; a lone requester always wins.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick0 = (burst_cnt_q != MaxBurst);
`else
    pick0 = last_winner_q;
`endif
    win0 = req0 & (~req1 | pick0);
    win1 = req1 & (~req0 | ~pick0);
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    sel_we    = 1'b0;
    sel_size  = 2'b10;
    sel_addr  = '0;
    sel_wdata = '0;
    if (win0) begin
      sel_we    = we0;
      sel_size  = size0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end else if (win1) begin
      sel_we    = we1;
      sel_size  = size1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  always_comb begin
    unique case (sel_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = sel_addr[0];
      2'b10:   misaligned = |sel_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Reset gates only the outward-facing strobes; the flops are held by the async reset anyway.
  assign gnt0      = rst_n & win0;
  assign gnt1      = rst_n & win1;
  assign mem_we    = rst_n & sel_we & ~misaligned;
  assign mem_size  = sel_size;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  always_comb begin
    rvalid0_d = win0;
    rvalid1_d = win1;
    err0_d    = win0 & misaligned;
    err1_d    = win1 & misaligned;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (win0 && misaligned)   rdata0_d = '0;
    else if (win0 && !sel_we) rdata0_d = mem_rdata;
    if (win1 && misaligned)   rdata1_d = '0;
    else if (win1 && !sel_we) rdata1_d = mem_rdata;

    last_winner_d = last_winner_q;
    if (win0)      last_winner_d = 1'b0;
    else if (win1) last_winner_d = 1'b1;

    // Counts port-0 wins over a waiting port 1; anything else breaks the streak.
    if (win0 && req1)
      burst_cnt_d = (burst_cnt_q == MaxBurst) ? burst_cnt_q : burst_cnt_q + 4'd1;
    else
      burst_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= 1'b1;
      burst_cnt_q   <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      // NOTE: only these few result registers are reset; the memory array itself lives outside.
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
